// File: rtl/freq_pkg.sv
// Shared types and constants for the edge-count frequency front end.
// The overflow digit choice lives in edge_count_bcd (macro OVF_BLANK_EN).
package freq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      TENS = 1'b1
   } state_t;

   localparam int         MAX_DISPLAY = 99;
   localparam int         DIGIT_BASE  = 10;
   localparam logic [3:0] BLANK_DIGIT = 4'hF;

endpackage

// File: rtl/edge_detect.sv
// Two-flop synchroniser plus history flop; emits a one-cycle pulse per rising
// edge of an asynchronous input, two cycles after the input is first sampled high.
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic edge_pulse
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= async_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign edge_pulse = s2 & ~s3;

endmodule

// File: rtl/edge_count_bcd.sv
// Counts rising edges of `signal` per UPDATE_PERIOD-clock window and reports the
// count as two BCD digits with a load strobe. Macro OVF_BLANK_EN: counts > 99 show blank (4'hF) instead of 99.
module edge_count_bcd
   import freq_pkg::*;
#(
   parameter int UPDATE_PERIOD = 1200,
   parameter int CNT_W         = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       signal,
   output logic [3:0] ten_count,
   output logic [3:0] unit_count,
   output logic       load
);

   localparam int             WIN_W    = $clog2(UPDATE_PERIOD);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(UPDATE_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] BASE     = CNT_W'(DIGIT_BASE);
   localparam logic [CNT_W-1:0] CLIP_AT  = CNT_W'(MAX_DISPLAY);

`ifdef OVF_BLANK_EN
   localparam logic [3:0] OVF_DIGIT = BLANK_DIGIT;
`else
   localparam logic [3:0] OVF_DIGIT = 4'(MAX_DISPLAY % DIGIT_BASE);
`endif

   logic             edge_pulse;
   logic [WIN_W-1:0] win_cnt;
   logic             win_end;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] edge_inc;
   logic [CNT_W-1:0] closing_cnt;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] work;
   logic [CNT_W-1:0] work_nxt;
   logic [3:0]       tens;
   logic [3:0]       tens_nxt;
   logic             clip;
   logic             clip_nxt;
   logic [3:0]       ten_nxt;
   logic [3:0]       unit_nxt;
   logic             load_nxt;

   edge_detect u_edge_detect (
      .clk        (clk),
      .reset      (reset),
      .async_in   (signal),
      .edge_pulse (edge_pulse)
   );

   assign win_end = (win_cnt == WIN_LAST);

   always_ff @(posedge clk) begin
      if (reset || win_end) begin
         win_cnt <= '0;
      end else begin
         win_cnt <= win_cnt + 1'b1;
      end
   end

   // An edge in the last window cycle is folded into the captured total,
   // so the counter can simply restart from zero on the following cycle.
   assign edge_inc    = (edge_cnt == CNT_MAX) ? edge_cnt : edge_cnt + 1'b1;
   assign closing_cnt = edge_pulse ? edge_inc : edge_cnt;

   always_ff @(posedge clk) begin
      if (reset || win_end) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= closing_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         work       <= '0;
         tens       <= '0;
         clip       <= 1'b0;
         ten_count  <= '0;
         unit_count <= '0;
         load       <= 1'b0;
      end else begin
         state      <= state_nxt;
         work       <= work_nxt;
         tens       <= tens_nxt;
         clip       <= clip_nxt;
         ten_count  <= ten_nxt;
         unit_count <= unit_nxt;
         load       <= load_nxt;
      end
   end

   // Handshake: load is a valid-only strobe with no ready; it is high for
   // exactly one cycle per window and the digits are stable whenever it is high
   // and until the next strobe.
   always_comb begin
      state_nxt = state;
      work_nxt  = work;
      tens_nxt  = tens;
      clip_nxt  = clip;
      ten_nxt   = ten_count;
      unit_nxt  = unit_count;
      load_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (win_end) begin
               work_nxt  = closing_cnt;
               clip_nxt  = (closing_cnt > CLIP_AT);
               tens_nxt  = '0;
               state_nxt = TENS;
            end
         end
         TENS: begin
            if (clip) begin
               ten_nxt   = OVF_DIGIT;
               unit_nxt  = OVF_DIGIT;
               load_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (work >= BASE) begin
               work_nxt = work - BASE;
               tens_nxt = tens + 4'd1;
            end else begin
               ten_nxt   = tens;
               unit_nxt  = work[3:0];
               load_nxt  = 1'b1;
               tens_nxt  = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_edge_count_bcd.sv
// Directed bench for edge_count_bcd (UPDATE_PERIOD=200): expected reports are
// queued by the stimulus and compared by a negedge monitor on every load strobe.
module tb_edge_count_bcd;

   localparam int UPDATE_PERIOD = 200;
   localparam int CNT_W         = 12;

`ifdef OVF_BLANK_EN
   localparam int OVF = 15;
`else
   localparam int OVF = 9;
`endif

   typedef struct packed {
      logic [3:0]  ten;
      logic [3:0]  unit;
      logic [31:0] cyc;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       signal;
   logic [3:0] ten_count;
   logic [3:0] unit_count;
   logic       load;

   exp_t exp_q[$];
   exp_t exp_e;
   int   cyc;
   int   checks;
   int   errors;

   edge_count_bcd #(
      .UPDATE_PERIOD (UPDATE_PERIOD),
      .CNT_W         (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .signal     (signal),
      .ten_count  (ten_count),
      .unit_count (unit_count),
      .load       (load)
   );

   // clock / reset-relative cycle index (equals the window position after reset)
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int c);
      while (cyc < c) step();
   endtask

   // n single-cycle high pulses; pulse i is detected by the DUT in cycle first+i*per
   task automatic edge_train(input int first, input int n, input int per);
      for (int i = 0; i < n; i++) begin
         goto(first + i * per - 2);
         signal = 1'b1;
         step();
         signal = 1'b0;
      end
   endtask

   task automatic push_exp(input int ten, input int unit, input int at);
      exp_t e;
      e.ten  = 4'(ten);
      e.unit = 4'(unit);
      e.cyc  = 32'(at);
      exp_q.push_back(e);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (load === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load: load=1 at cycle %0d, expected no strobe", cyc);
         end else begin
            exp_e = exp_q.pop_front();
            check("load_cycle", 32'(cyc), exp_e.cyc);
            check("ten_count", 32'(ten_count), 32'(exp_e.ten));
            check("unit_count", 32'(unit_count), 32'(exp_e.unit));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      signal = 1'b0;
      repeat (3) step();
      check("reset_ten", 32'(ten_count), 32'd0);
      check("reset_unit", 32'(unit_count), 32'd0);
      check("reset_load", 32'(load), 32'd0);
      reset = 1'b0;

      // window 0: silence -> 0/0 at W+2
      push_exp(0, 0, 201);
      // window 1: 42 edges, period 4 -> 4/2 at W+6
      push_exp(4, 2, 405);
      edge_train(210, 42, 4);
      // window 2: 100 edges -> clipped, reported at W+2
      push_exp(OVF, OVF, 601);
      edge_train(400, 100, 2);
      // window 3: 99 edges -> largest unclipped value at W+11
      push_exp(9, 9, 810);
      edge_train(600, 99, 2);
      // window 4: last edge detected exactly in W belongs to this window
      push_exp(0, 5, 1001);
      edge_train(900, 4, 10);
      edge_train(999, 1, 2);
      // window 5: no edge in W; window 6 opens with an edge in W+1
      push_exp(0, 2, 1201);
      edge_train(1100, 2, 10);
      push_exp(0, 3, 1401);
      edge_train(1200, 3, 10);
      // windows 7..11: steady 10 edges each -> 1/0 every UPDATE_PERIOD
      for (int w = 7; w <= 11; w++) begin
         push_exp(1, 0, 200 * w + 202);
         edge_train(200 * w + 50, 10, 5);
      end
      // window 12: 87 edges, reset lands while dividing -> no report
      edge_train(2410, 87, 2);
      goto(2603);
      reset = 1'b1;
      step();
      check("abort_ten", 32'(ten_count), 32'd0);
      check("abort_unit", 32'(unit_count), 32'd0);
      check("abort_load", 32'(load), 32'd0);
      step();
      reset = 1'b0;
      // first window after reset: 27 edges -> 2/7 at W+4
      push_exp(2, 7, 203);
      edge_train(20, 27, 3);
      goto(215);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
